// File: rtl/rgb_pwm_pkg.sv
// Shared types for the RGB LED PWM controller: channel modes and breathe FSM states.
package rgb_pwm_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_SOLID   = 2'b01,
        MODE_BLINK   = 2'b10,
        MODE_BREATHE = 2'b11
    } mode_t;

    typedef enum logic {
        ST_UP   = 1'b0,
        ST_DOWN = 1'b1
    } breathe_state_t;

endpackage

// File: rtl/rgb_pwm_channel.sv
// One PWM channel: shadow/active config, breathe level FSM, effective-duty mux and
// registered comparator against the shared PWM counter.
module rgb_pwm_channel
    import rgb_pwm_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic                hw_clk,
    input  logic                rst,
    input  logic                period_end,
    input  logic                step,
    input  logic                blink_phase,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic                wr_sel,
    input  logic [1:0]          wr_mode,
    input  logic [PWM_BITS-1:0] wr_duty,
    output logic                pwm_o
);

    localparam logic [PWM_BITS-1:0] MAX = '1;
    localparam logic [PWM_BITS-1:0] ONE = PWM_BITS'(1);

    mode_t               sh_mode, act_mode, load_mode;
    logic [PWM_BITS-1:0] sh_duty, act_duty, load_duty;
    breathe_state_t      state, state_d;
    logic [PWM_BITS-1:0] level, level_d;
    logic [PWM_BITS-1:0] eff;
    logic                pwm_d;

    // A write landing on the boundary cycle is loaded directly, skipping the shadow.
    assign load_mode = wr_sel ? mode_t'(wr_mode) : sh_mode;
    assign load_duty = wr_sel ? wr_duty : sh_duty;

    always_ff @(posedge hw_clk) begin
        if (rst) begin
            sh_mode  <= MODE_OFF;
            sh_duty  <= '0;
            act_mode <= MODE_OFF;
            act_duty <= '0;
            state    <= ST_UP;
            level    <= '0;
            pwm_o    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register here samples pre-edge values.
            if (wr_sel) begin
                sh_mode <= mode_t'(wr_mode);
                sh_duty <= wr_duty;
            end
            if (period_end) begin
                act_mode <= load_mode;
                act_duty <= load_duty;
            end
            state <= state_d;
            level <= level_d;
            pwm_o <= pwm_d;
        end
    end

    // Turnarounds reverse and step on the same strobe, giving a clean triangle 0..duty..0.
    always_comb begin
        // NOTE: defaults first so no path through this block infers a latch.
        state_d = state;
        level_d = level;
        if (period_end && load_mode == MODE_BREATHE) begin
            if (act_mode != MODE_BREATHE) begin
                state_d = ST_UP;
                level_d = '0;
            end else if (load_duty < level) begin
                state_d = ST_DOWN;
                level_d = load_duty;
            end else if (step) begin
                if (load_duty == '0) begin
                    level_d = '0;
                end else if (state == ST_UP) begin
                    if (level < load_duty) begin
                        level_d = level + ONE;
                    end else begin
                        state_d = ST_DOWN;
                        level_d = level - ONE;
                    end
                end else begin
                    if (level != '0) begin
                        level_d = level - ONE;
                    end else begin
                        state_d = ST_UP;
                        level_d = level + ONE;
                    end
                end
            end
        end
    end

    always_comb begin
        eff = '0;
        unique case (act_mode)
            MODE_OFF:     eff = '0;
            MODE_SOLID:   eff = act_duty;
            MODE_BLINK:   eff = blink_phase ? act_duty : '0;
            MODE_BREATHE: eff = level;
        endcase
        // Full scale must stay high through the MAX count, which the compare alone would miss.
        pwm_d = (eff == MAX) ? 1'b1 : (pwm_cnt < eff);
    end

endmodule

// File: rtl/rgb_pwm_ctrl.sv
// Multi-channel RGB LED PWM controller: prescaler, shared PWM/blink/step timebase,
// config write decode, and one rgb_pwm_channel per output.
module rgb_pwm_ctrl
    import rgb_pwm_pkg::*;
#(
    parameter  int NUM_CH        = 3,
    parameter  int PWM_BITS      = 8,
    parameter  int PRESCALE      = 16,
    parameter  int BLINK_PERIODS = 64,
    parameter  int STEP_PERIODS  = 2,
    localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                hw_clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [1:0]          wr_mode,
    input  logic [PWM_BITS-1:0] wr_duty,
    output logic [NUM_CH-1:0]   pwm_o,
    output logic                period_o,
    output logic                blink_phase_o
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int BLK_W = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
    localparam int STP_W = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;

    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [BLK_W-1:0]    BLK_LAST = BLK_W'(BLINK_PERIODS - 1);
    localparam logic [STP_W-1:0]    STP_LAST = STP_W'(STEP_PERIODS - 1);
    localparam logic [PWM_BITS-1:0] PWM_MAX  = '1;
    localparam logic [CH_W:0]       NUM_CH_V = (CH_W + 1)'(NUM_CH);

    logic [PRE_W-1:0]    pre_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [BLK_W-1:0]    blink_cnt;
    logic [STP_W-1:0]    step_cnt;
    logic                blink_phase;
    logic                tick, period_end, step, wr_valid;

    assign tick          = (pre_cnt == PRE_LAST);
    assign period_end    = tick && (pwm_cnt == PWM_MAX);
    assign step          = period_end && (step_cnt == STP_LAST);
    assign wr_valid      = wr_en && ({1'b0, wr_ch} < NUM_CH_V);
    assign blink_phase_o = blink_phase;

    always_ff @(posedge hw_clk) begin
        if (rst) begin
            pre_cnt     <= '0;
            pwm_cnt     <= '0;
            blink_cnt   <= '0;
            step_cnt    <= '0;
            blink_phase <= 1'b0;
            period_o    <= 1'b0;
        end else begin
            pre_cnt  <= tick ? '0 : pre_cnt + PRE_W'(1);
            period_o <= period_end;
            if (tick) begin
                pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            end
            if (period_end) begin
                if (blink_cnt == BLK_LAST) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + BLK_W'(1);
                end
                step_cnt <= (step_cnt == STP_LAST) ? '0 : step_cnt + STP_W'(1);
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        rgb_pwm_channel #(
            .PWM_BITS(PWM_BITS)
        ) u_ch (
            .hw_clk     (hw_clk),
            .rst        (rst),
            .period_end (period_end),
            .step       (step),
            .blink_phase(blink_phase),
            .pwm_cnt    (pwm_cnt),
            .wr_sel     (wr_valid && (wr_ch == CH_W'(i))),
            .wr_mode    (wr_mode),
            .wr_duty    (wr_duty),
            .pwm_o      (pwm_o[i])
        );
    end

endmodule

// File: doc/rgb_pwm_ctrl.md
Name: rgb_pwm_ctrl

Overview:
Parametrised multi-channel PWM controller for the on-board RGB LED. Each channel has a programmable duty and mode: off, solid, blink or breathe. The top level runs it from hw_clk and wires pwm_o[i] to the RGBxPWM inputs of SB_RGBA_DRV, replacing tie-off constants. Duty and mode changes are glitch-free: they are applied only at PWM period boundaries.

Parameters:
NUM_CH, 3, number of independent PWM channels (1..8)
PWM_BITS, 8, duty/counter width; PWM period = 2^PWM_BITS ticks
PRESCALE, 16, hw_clk cycles per PWM tick (>=1)
BLINK_PERIODS, 64, PWM periods per blink half-cycle (>=1)
STEP_PERIODS, 2, PWM periods per breathe level step (>=1)
(localparam CH_W = max(1, clog2(NUM_CH)))

Ports:
hw_clk  in  1  sole clock
rst  in  1  synchronous, active-high reset
wr_en  in  1  config write strobe, single cycle
wr_ch  in  CH_W  target channel
wr_mode  in  2  00 OFF, 01 SOLID, 10 BLINK, 11 BREATHE
wr_duty  in  PWM_BITS  duty (SOLID/BLINK) or peak level (BREATHE)
pwm_o  out  NUM_CH  registered PWM outputs
period_o  out  1  one-cycle pulse at each PWM period end
blink_phase_o  out  1  current global blink phase

Behaviour:
- One clock (hw_clk); reset is synchronous and active-high (rst). When rst=1 at a clock edge, every register clears: pwm_o=0, period_o=0, blink_phase_o=0, all modes OFF, all duties 0, breathe FSMs UP with level 0, all counters 0.
- Prescaler: pre_cnt counts 0..PRESCALE-1. tick=1 on the cycle where pre_cnt==PRESCALE-1. PRESCALE=1 gives tick every cycle.
- PWM counter: pwm_cnt increments on tick and wraps from MAX=2^PWM_BITS-1 to 0. period_end = tick && pwm_cnt==MAX. period_o is period_end registered.
- Config: wr_en with wr_ch<NUM_CH writes that channel's shadow mode/duty. wr_en with wr_ch>=NUM_CH is ignored. Multiple writes before a boundary: the last write wins.
- At period_end, active mode/duty load from shadow. A write in the same cycle as period_end bypasses the shadow and is loaded directly.
- Blink: blink_cnt counts period_ends 0..BLINK_PERIODS-1. blink_phase toggles on wrap. Phase starts 0 = dark.
- Effective duty eff per channel:
  - OFF: 0
  - SOLID: duty
  - BLINK: blink_phase ? duty : 0
  - BREATHE: level
- Breathe FSM, per channel; steps on step strobe = every STEP_PERIODS-th period_end:
  - UP: level<duty → level+1; level>=duty → DOWN.
  - DOWN: level>0 → level-1; level==0 → UP.
  - duty==0 → level held at 0.
  - Entering BREATHE from another mode (at load) resets level=0, state UP.
  - If the loaded duty is below the current level: level clamps to duty, state DOWN.
- Output compare, registered, 1-cycle latency from pwm_cnt:
  - eff==MAX → pwm_o[i]=1 continuously.
  - eff==0 → 0.
  - otherwise pwm_o[i] = (pwm_cnt < eff).
- Channels are independent. Arithmetic is unsigned, with no overflow: level is bounded to 0..duty.

Decomposition:
- Package rgb_pwm_pkg: mode constants MODE_OFF/SOLID/BLINK/BREATHE (2-bit), breathe state constants ST_UP/ST_DOWN.
- Sub-module rgb_pwm_channel: shadow/active regs, breathe FSM, eff mux and comparator. It is generated NUM_CH times.
- The top holds the prescaler, pwm_cnt, blink and step counters, and write decode.

Test Plan:
(Run with PWM_BITS=4, PRESCALE=1, BLINK_PERIODS=2, STEP_PERIODS=1 unless stated.)
- Reset and SOLID duty: hold rst 3 cycles → all outputs 0. Write ch0 SOLID duty=4 → after the next period_end, pwm_o[0] is high exactly 4 of every 16 cycles; ch1/ch2 stay 0.
- Duty boundaries: SOLID duty=15 → pwm_o[0] constant 1. duty=0 → constant 0. Write ch=3 (invalid) → no channel changes.
- Glitch-free update: change duty 4→10 mid-period → current period still shows a 4-cycle pulse, next period a 10-cycle pulse. Two writes (6, then 9) in one period → 9 applied.
- Blink: BLINK duty=8 → two periods dark, two periods 8/16, repeating. blink_phase_o toggles every 32 cycles.
- Breathe: BREATHE duty=3 → per-period high counts 0,1,2,3,2,1,0,1… Rewrite duty=1 while level=3 → next period level=1, state DOWN.
- Reset mid-operation and simultaneous write: assert rst during BREATHE → next cycle pwm_o=0 and mode OFF. A write coincident with period_end takes effect in that same next period.
